// File: rtl/audio_sample_sequencer.sv
// -----------------------------------------------------------------------------
// audio_sample_sequencer
//
// Moves one stereo sample at a time from the codec read FIFO, through the
// filter datapath (start/done handshake), into the codec write FIFO. One FSM
// owns both codec handshakes and the filter handshake.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   -> filter watchdog. After TIMEOUT_CYC WAIT cycles without
//                filt_done, the raw sample is bypassed to the codec and the
//                sticky timeout flag is set.
//   undefined -> WAIT holds indefinitely, timeout is tied low and no
//                counter exists.
//
// Parameters
//   DATA_W       sample width per channel
//   TIMEOUT_CYC  watchdog limit in WAIT cycles (SEQ_TIMEOUT_EN only)
//
// Ports
//   CLOCK_50                          in   system clock, rising edge
//   reset                             in   asynchronous active-high reset
//   enable                            in   run request, sampled in IDLE only
//   read_ready                        in   codec read FIFO non-empty
//   readdata_left/right   [DATA_W]    in   codec input samples
//   read                              out  codec pop strobe (CAPTURE)
//   write_ready                       in   codec write FIFO has space
//   writedata_left/right  [DATA_W]    out  samples to codec
//   write                             out  codec push strobe (WRITE)
//   filt_start                        out  filter start pulse (START)
//   filt_in_left/right    [DATA_W]    out  filter operands (sample registers)
//   filt_done                         in   filter result valid pulse
//   filt_out_left/right   [DATA_W]    in   filter results
//   busy                              out  FSM not in IDLE
//   sample_count          [16]        out  samples written, wraps at 16 bits
//   timeout                           out  sticky watchdog flag
// -----------------------------------------------------------------------------
module audio_sample_sequencer #(
  parameter int DATA_W      = 24,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              write,
  output logic              filt_start,
  output logic [DATA_W-1:0] filt_in_left,
  output logic [DATA_W-1:0] filt_in_right,
  input  logic              filt_done,
  input  logic [DATA_W-1:0] filt_out_left,
  input  logic [DATA_W-1:0] filt_out_right,
  output logic              busy,
  output logic [15:0]       sample_count,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CAPTURE    = 3'd1,
    S_START      = 3'd2,
    S_WAIT       = 3'd3,
    S_WRITE_WAIT = 3'd4,
    S_WRITE      = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              capture_in_s;   // latch codec samples this edge
  logic              capture_out_s;  // latch filter results this edge
  logic              bypass_s;       // watchdog expiry: copy raw samples out
  logic              expire_s;
  logic [DATA_W-1:0] in_left_r;
  logic [DATA_W-1:0] in_right_r;
  logic [DATA_W-1:0] out_left_r;
  logic [DATA_W-1:0] out_right_r;
  logic [15:0]       count_r;

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt_r;
  logic             timeout_r;

  // The counter holds the number of WAIT cycles already completed, so the
  // TIMEOUT_CYC-th WAIT cycle is the one where it equals TIMEOUT_CYC-1.
  assign expire_s = (state_r == S_WAIT) && (wd_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout  = timeout_r;

  // Watchdog counter: cleared while heading into WAIT, counts WAIT cycles.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wd_cnt_r <= '0;
    end else if (state_r == S_START) begin
      wd_cnt_r <= '0;
    end else if (state_r == S_WAIT) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // Sticky timeout flag, set only when the bypass path is taken.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      timeout_r <= 1'b0;
    end else if (bypass_s) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end
`else
  assign expire_s = 1'b0;
  assign timeout  = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath-enable decode.
  always_comb begin
    state_next_s  = state_r;
    capture_in_s  = 1'b0;
    capture_out_s = 1'b0;
    bypass_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (enable && read_ready) begin
          state_next_s = S_CAPTURE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_CAPTURE: begin
        capture_in_s = 1'b1;
        state_next_s = S_START;
      end
      S_START: begin
        // filt_done is deliberately ignored here.
        state_next_s = S_WAIT;
      end
      S_WAIT: begin
        // A real result beats a simultaneous watchdog expiry.
        if (filt_done) begin
          capture_out_s = 1'b1;
          state_next_s  = S_WRITE_WAIT;
        end else if (expire_s) begin
          bypass_s     = 1'b1;
          state_next_s = S_WRITE_WAIT;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_WRITE_WAIT: begin
        if (write_ready) begin
          state_next_s = S_WRITE;
        end else begin
          state_next_s = S_WRITE_WAIT;
        end
      end
      S_WRITE: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Sample registers: hold the popped codec pair as filter operands.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      in_left_r  <= '0;
      in_right_r <= '0;
    end else if (capture_in_s) begin
      in_left_r  <= readdata_left;
      in_right_r <= readdata_right;
    end else begin
      in_left_r  <= in_left_r;
      in_right_r <= in_right_r;
    end
  end

  // Output registers: filtered result, or raw sample on watchdog bypass.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      out_left_r  <= '0;
      out_right_r <= '0;
    end else if (capture_out_s) begin
      out_left_r  <= filt_out_left;
      out_right_r <= filt_out_right;
    end else if (bypass_s) begin
      out_left_r  <= in_left_r;
      out_right_r <= in_right_r;
    end else begin
      out_left_r  <= out_left_r;
      out_right_r <= out_right_r;
    end
  end

  // Written-sample counter, wraps naturally at 16 bits.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count_r <= 16'd0;
    end else if (state_r == S_WRITE) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Moore outputs decoded from the registered state only.
  assign read            = (state_r == S_CAPTURE);
  assign filt_start      = (state_r == S_START);
  assign write           = (state_r == S_WRITE);
  assign busy            = (state_r != S_IDLE);
  assign filt_in_left    = in_left_r;
  assign filt_in_right   = in_right_r;
  assign writedata_left  = out_left_r;
  assign writedata_right = out_right_r;
  assign sample_count    = count_r;

endmodule

// File: doc/audio_sample_sequencer.md
# audio_sample_sequencer

Controller that sequences one stereo sample at a time through the audio path:
- pops a left/right pair from the codec read FIFO;
- hands it to the filter datapath with a start/done handshake;
- pushes the filtered pair into the codec write FIFO.

It sits between the audio codec core and the filter in the part2 top level and replaces ad-hoc read/write glue with one FSM that owns both codec handshakes.

## Interface
Parameters:
- DATA_W, 24, sample width per channel
- TIMEOUT_CYC, 1023, filter watchdog limit in cycles (used only with SEQ_TIMEOUT_EN)

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request; sampled only in IDLE
- read_ready  in  1  codec read FIFO non-empty; readdata_* valid while high
- readdata_left, readdata_right  in  DATA_W  codec input samples
- read  out  1  codec pop strobe
- write_ready  in  1  codec write FIFO has space
- writedata_left, writedata_right  out  DATA_W  samples to codec
- write  out  1  codec push strobe
- filt_start  out  1  one-cycle filter start pulse
- filt_in_left, filt_in_right  out  DATA_W  filter operands; stable from START until the next CAPTURE
- filt_done  in  1  filter result valid, one-cycle pulse
- filt_out_left, filt_out_right  in  DATA_W  filter results; valid with filt_done
- busy  out  1  high in any state other than IDLE
- sample_count  out  16  samples written to codec, wraps 0xFFFF→0x0000
- timeout  out  1  sticky filter-watchdog flag

## Operation
FSM states: IDLE, CAPTURE, START, WAIT, WRITE_WAIT, WRITE. State outputs are Moore, decoded from the registered state.
- IDLE:
  - read, write and filt_start are 0.
  - enable && read_ready → CAPTURE. Otherwise stay.
- CAPTURE:
  - read=1 for exactly this cycle.
  - On the exit edge, readdata_left/right are latched into the sample registers, which drive filt_in_*.
  - Next state: START unconditionally.
- START:
  - filt_start=1 for exactly this cycle.
  - Next state: WAIT. filt_done is ignored in START.
- WAIT:
  - On filt_done=1, filt_out_* are latched into the output registers, which drive writedata_*; next state WRITE_WAIT.
  - Otherwise stay.
- WRITE_WAIT: write_ready=1 → WRITE. Otherwise stay; no timeout applies here.
- WRITE:
  - write=1 for exactly this cycle.
  - sample_count increments by 1, modulo 2^16.
  - Next state: IDLE.

Rules:
- enable deasserted mid-sample: the current sample completes through WRITE, then the FSM stays in IDLE.
- read_ready toggling outside IDLE/CAPTURE has no effect; the codec FIFO buffers the data.
- writedata_* change only on filt_done capture, or on timeout bypass (see Configuration).
- Arithmetic: no width change; data passes through registers unmodified, with no sign extension or truncation.
- Reset (asynchronous, any state): state=IDLE; read, write, filt_start, busy, timeout = 0; sample_count = 0; all data registers = 0. Any in-flight sample is discarded; the codec and filter are not notified.

## Timing
- The cycle where IDLE sees enable && read_ready is cycle 0. Then:
  - read=1 in cycle 1;
  - filt_start=1 in cycle 2;
  - WAIT from cycle 3.
- filt_done in cycle N (N≥3) → WRITE_WAIT in cycle N+1. With write_ready=1, write=1 in cycle N+2.
- Minimum read-to-write latency: 4 cycles from read to write, 5 from detection.
- Back-to-back: after WRITE, IDLE is entered and the next CAPTURE can occur in the cycle after that. Minimum throughput is one sample per 6 cycles + filter latency.
- Handshake pulses:
  - read, write and filt_start are each a single cycle per sample.
  - They are never asserted simultaneously.
  - None is asserted in the cycle reset is released.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A 10-bit (clog2(TIMEOUT_CYC+1)) counter clears on entering WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT_CYC without filt_done: timeout is set (sticky until reset), the raw sample registers are copied to writedata_* (bypass), and the next state is WRITE_WAIT.
  - filt_done in the same cycle as expiry wins: the filtered data is used and timeout is not set.
- SEQ_TIMEOUT_EN undefined:
  - WAIT holds indefinitely.
  - timeout is tied 0.
  - No counter is synthesized.

## Test plan
- Reset: assert reset mid-WAIT → all outputs 0 and state IDLE immediately, without waiting for a clock; sample_count=0.
- Single sample:
  - Stimulus: enable=1; read_ready=1 with readdata_right=1000000, readdata_left=5; filter returns filt_done after 3 WAIT cycles with filt_out_right=1000002; write_ready=1.
  - Response: read pulse 1 cycle, then filt_start pulse, filt_in_right=1000000; write pulse with writedata_right=1000002; sample_count=1.
- Stream: read_ready held high, readdata_right stepping 1000001..1000008, filter done in 1 cycle → 8 writes in order, each a single-cycle strobe; sample_count=8.
- Backpressure: write_ready=0 for 20 cycles after filt_done → FSM holds WRITE_WAIT, write=0, writedata stable; write fires 1 cycle after write_ready rises.
- enable drop: deassert enable during WAIT → the current sample is written; no further read while read_ready stays high.
- Watchdog (SEQ_TIMEOUT_EN, TIMEOUT_CYC=8): filt_done never asserted → timeout=1 after 8 WAIT cycles; writedata_right equals the raw input 1000010; write pulses once.
